bcd_xs3_serial_conv: RTL and testbench



---
 rtl/bcd_xs3_serial_conv.sv | 141 ++++++++++++++
 tb/tb_bcd_xs3_serial_conv.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_serial_conv.sv
`default_nettype none
// ============================================================================
// Module   : bcd_xs3_serial_conv
// Brief    : Serial BCD-to-Excess-3 converter (LSB first, falling-edge state).
//            Optional BCD range checker enabled by macro BCD_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_xs3_serial_conv #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             X,
    input  logic             XV,
    output logic             Z,
    output logic             ZV,
    output logic             DigitDone,
    output logic [3:0]       XS3_Q,
    output logic [CNT_W-1:0] DCount,
    output logic             Err
);

    // State encodes (bit position, carry) of the running +3 addition.
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;

    logic [2:0]       r_state_q, w_state_d;
    logic             r_z_q, w_z_d;
    logic             r_zv_q, w_zv_d;
    logic             r_done_q, w_done_d;
    logic [3:0]       r_sr_q, w_sr_d;
    logic [3:0]       r_xs3_q, w_xs3_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    logic       w_z;
    logic [2:0] w_state_nxt;
    logic       w_last;

    always_comb begin
        w_z         = 1'b0;
        w_state_nxt = S0;
        w_last      = 1'b0;
        case (r_state_q)
            S0: begin w_z = ~X; w_state_nxt = X ? S2 : S1; end
            S1: begin w_z = ~X; w_state_nxt = X ? S4 : S3; end
            S2: begin w_z =  X; w_state_nxt = S4;          end
            S3: begin w_z =  X; w_state_nxt = S5;          end
            S4: begin w_z = ~X; w_state_nxt = X ? S6 : S5; end
            S5: begin w_z =  X; w_state_nxt = S0; w_last = 1'b1; end
            S6: begin w_z = ~X; w_state_nxt = S0; w_last = 1'b1; end
            default: begin w_z = 1'b0; w_state_nxt = S0; end
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_z_d     = r_z_q;
        w_zv_d    = 1'b0;
        w_done_d  = 1'b0;
        w_sr_d    = r_sr_q;
        w_xs3_d   = r_xs3_q;
        w_cnt_d   = r_cnt_q;
        if (XV) begin
            w_state_d = w_state_nxt;
            w_z_d     = w_z;
            w_zv_d    = 1'b1;
            w_sr_d    = {w_z, r_sr_q[3:1]};
            if (w_last) begin
                w_done_d = 1'b1;
                w_xs3_d  = {w_z, r_sr_q[3:1]};
                w_cnt_d  = r_cnt_q + CNT_W'(1);
                w_sr_d   = 4'd0;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (Clr) begin
            r_state_q <= S0;
            r_z_q     <= 1'b0;
            r_zv_q    <= 1'b0;
            r_done_q  <= 1'b0;
            r_sr_q    <= 4'd0;
            r_xs3_q   <= 4'd0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_z_q     <= w_z_d;
            r_zv_q    <= w_zv_d;
            r_done_q  <= w_done_d;
            r_sr_q    <= w_sr_d;
            r_xs3_q   <= w_xs3_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

`ifdef BCD_CHECK_EN
    // Raw input nibble, shifted in LSB first alongside the conversion.
    logic [3:0] r_nib_q, w_nib_d;
    logic       r_err_q, w_err_d;

    always_comb begin
        w_nib_d = r_nib_q;
        w_err_d = 1'b0;
        if (XV) begin
            w_nib_d = {X, r_nib_q[3:1]};
            if (w_last) begin
                w_err_d = ({X, r_nib_q[3:1]} > 4'd9);
                w_nib_d = 4'd0;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (Clr) begin
            r_nib_q <= 4'd0;
            r_err_q <= 1'b0;
        end else begin
            r_nib_q <= w_nib_d;
            r_err_q <= w_err_d;
        end
    end

    assign Err = r_err_q;
`else
    assign Err = 1'b0;
`endif

    assign Z         = r_z_q;
    assign ZV        = r_zv_q;
    assign DigitDone = r_done_q;
    assign XS3_Q     = r_xs3_q;
    assign DCount    = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_xs3_serial_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_xs3_serial_conv
// Brief    : Scoreboard bench for bcd_xs3_serial_conv (8-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_xs3_serial_conv;

    logic       CLK = 1'b0;
    logic       Clr = 1'b1;
    logic       X   = 1'b0;
    logic       XV  = 1'b0;

    logic       w_z, w_zv, w_done, w_err;
    logic [3:0] w_xs3;
    logic [7:0] w_cnt;
    logic       w_z2, w_zv2, w_done2, w_err2;
    logic [3:0] w_xs32;
    logic [1:0] w_cnt2;

    bcd_xs3_serial_conv #(.CNT_W(8)) u_dut (
        .CLK(CLK), .Clr(Clr), .X(X), .XV(XV),
        .Z(w_z), .ZV(w_zv), .DigitDone(w_done),
        .XS3_Q(w_xs3), .DCount(w_cnt), .Err(w_err)
    );

    bcd_xs3_serial_conv #(.CNT_W(2)) u_dut_w2 (
        .CLK(CLK), .Clr(Clr), .X(X), .XV(XV),
        .Z(w_z2), .ZV(w_zv2), .DigitDone(w_done2),
        .XS3_Q(w_xs32), .DCount(w_cnt2), .Err(w_err2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       z;
        logic       done;
        logic [3:0] xs3;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       err;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks   = 0;
    int   n_failures = 0;

    int         m_pos  = 0;
    logic [3:0] m_nib  = 4'd0;
    logic [7:0] m_cnt  = 8'd0;
    logic       last_z = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected bit i of (nibble+3) depends only on input bits 0..i.
    task automatic send_bit(input logic b);
        exp_t       e;
        logic [3:0] sum;
        @(posedge CLK);
        Clr = 1'b0; XV = 1'b1; X = b;
        m_nib[m_pos] = b;
        sum    = m_nib + 4'd3;
        e.z    = sum[m_pos];
        e.done = (m_pos == 3);
        e.xs3  = sum;
        e.err  = 1'b0;
        if (e.done) begin
            m_cnt++;
`ifdef BCD_CHECK_EN
            e.err = (m_nib > 4'd9);
`endif
        end
        e.cnt  = m_cnt;
        e.cnt2 = m_cnt[1:0];
        q_exp.push_back(e);
        if (m_pos == 3) begin m_pos = 0; m_nib = 4'd0; end
        else m_pos++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            Clr = 1'b0; XV = 1'b0; X = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic send_digit(input logic [3:0] d, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(d[i]);
            if (gap > 0) idle(gap);
        end
    endtask

    // A bit presented with Clr high must be dropped.
    task automatic do_clr();
        @(posedge CLK);
        Clr = 1'b1; XV = 1'b1; X = 1'b1;
        m_pos = 0; m_nib = 4'd0; m_cnt = 8'd0;
    endtask

    always begin
        logic c;
        exp_t e;
        @(negedge CLK);
        c = Clr;
        #2;
        if (c) begin
            check_val("rst_z",    w_z,    0);
            check_val("rst_zv",   w_zv,   0);
            check_val("rst_done", w_done, 0);
            check_val("rst_xs3",  w_xs3,  0);
            check_val("rst_cnt",  w_cnt,  0);
            check_val("rst_cnt2", w_cnt2, 0);
            check_val("rst_err",  w_err,  0);
            last_z = 1'b0;
        end else if (w_zv) begin
            if (q_exp.size() == 0) begin
                check_val("zv_spurious", 1, 0);
            end else begin
                e = q_exp.pop_front();
                check_val("z",    w_z,    e.z);
                check_val("done", w_done, e.done);
                check_val("err",  w_err,  e.err);
                check_val("zv2",  w_zv2,  1);
                if (e.done) begin
                    check_val("xs3",  w_xs3,  e.xs3);
                    check_val("cnt",  w_cnt,  e.cnt);
                    check_val("cnt2", w_cnt2, e.cnt2);
                end
            end
            last_z = w_z;
        end else begin
            check_val("z_hold",    w_z,    last_z);
            check_val("done_idle", w_done, 0);
            check_val("err_idle",  w_err,  0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_clr();
        send_digit(4'd0, 0);
        send_digit(4'd9, 0);
        send_digit(4'd5, 0);
        idle(2);
        send_digit(4'd7, 3);
        send_bit(1'b1);
        send_bit(1'b0);
        do_clr();
        send_digit(4'd2, 0);
        send_digit(4'd13, 1);
        do_clr();
        for (int i = 0; i < 5; i++) send_digit(4'd0, 0);
        for (int i = 0; i < 10; i++) send_digit(4'($urandom_range(15, 0)), $urandom_range(2, 0));
        idle(4);
        check_val("queue_empty", q_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
